uart_rx_ctrl: RTL

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: sequences start, data, parity and stop bits.
// Define UART_RX_ERR_CNT_EN to build the saturating frame-error counter.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_in,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               par_en,
    input  logic               sampled_bit,
    input  logic               par_err,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [3:0]         bit_cnt,
    output logic               dat_samp_en,
    output logic               deser_en,
    output logic               par_chk_en,
    output logic               data_valid,
    output logic               strt_glitch,
    output logic               stp_err,
    output logic [7:0]         err_cnt
);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, CHECK
    } state_e;

    localparam logic [PRESC_W-1:0] ONE   = PRESC_W'(1);
    localparam logic [PRESC_W-1:0] TWO   = PRESC_W'(2);
    localparam logic [PRESC_W-1:0] THREE = PRESC_W'(3);
    localparam logic [3:0]         LAST  = 4'(DATA_WIDTH);

    state_e             state_q;
    logic [PRESC_W-1:0] p_q;
    logic [PRESC_W-1:0] edge_q;
    logic [3:0]         bit_q;
    logic               err_q;
    logic               samp_q;
    logic               deser_q;
    logic               pchk_q;
    logic               dv_q;
    logic               glitch_q;
    logic               stp_q;
    logic               bit_end;
    logic               bit_pre;
    logic               pchk_pre;

    assign bit_end  = (edge_q == p_q - ONE);
    assign bit_pre  = (edge_q == p_q - TWO);
    assign pchk_pre = (edge_q == p_q - THREE);

    // Strobes are decided one clock early so the registered pulse lines up
    // with the last clock of the bit (edge_cnt == P-1).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            p_q      <= '0;
            edge_q   <= '0;
            bit_q    <= '0;
            err_q    <= 1'b0;
            samp_q   <= 1'b0;
            deser_q  <= 1'b0;
            pchk_q   <= 1'b0;
            dv_q     <= 1'b0;
            glitch_q <= 1'b0;
            stp_q    <= 1'b0;
        end else begin
            deser_q  <= 1'b0;
            pchk_q   <= 1'b0;
            dv_q     <= 1'b0;
            glitch_q <= 1'b0;
            stp_q    <= 1'b0;
            if (state_q inside {START, DATA, PARITY, STOP}) begin
                if (bit_end) begin
                    edge_q <= '0;
                    bit_q  <= bit_q + 4'd1;
                end else begin
                    edge_q <= edge_q + ONE;
                end
            end
            unique case (state_q)
                IDLE: begin
                    if (!rx_in) begin
                        state_q <= START;
                        p_q     <= prescale;
                        edge_q  <= '0;
                        bit_q   <= '0;
                        err_q   <= 1'b0;
                        samp_q  <= 1'b1;
                    end
                end
                START: begin
                    if (bit_pre) glitch_q <= sampled_bit;
                    if (bit_end) begin
                        if (glitch_q) begin
                            state_q <= IDLE;
                            samp_q  <= 1'b0;
                            bit_q   <= '0;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (bit_pre) deser_q <= 1'b1;
                    if (bit_end && bit_q == LAST)
                        state_q <= par_en ? PARITY : STOP;
                end
                PARITY: begin
                    if (pchk_pre) pchk_q <= 1'b1;
                    if (bit_end) begin
                        err_q   <= err_q | par_err;
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (bit_pre && !sampled_bit) begin
                        stp_q <= 1'b1;
                        err_q <= 1'b1;
                    end
                    if (bit_end) begin
                        state_q <= CHECK;
                        samp_q  <= 1'b0;
                        dv_q    <= !err_q;
                        bit_q   <= '0;
                    end
                end
                CHECK: begin
                    if (!rx_in) begin
                        state_q <= START;
                        p_q     <= prescale;
                        edge_q  <= '0;
                        bit_q   <= '0;
                        err_q   <= 1'b0;
                        samp_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // A glitch ends its frame in START; other errors are counted in CHECK.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= '0;
        end else if ((glitch_q || (state_q == CHECK && err_q)) &&
                     err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

    assign edge_cnt    = edge_q;
    assign bit_cnt     = bit_q;
    assign dat_samp_en = samp_q;
    assign deser_en    = deser_q;
    assign par_chk_en  = pchk_q;
    assign data_valid  = dv_q;
    assign strt_glitch = glitch_q;
    assign stp_err     = stp_q;

endmodule
